// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port among several requesters.
// Granted indices are queued in order so responses return to their owner.
package obi_pkg;

  typedef struct packed {
    logic UseRReady;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module obi_rr_arbiter #(
  parameter obi_pkg::obi_cfg_t ObiCfg =
    obi_pkg::ObiDefaultConfig,
  parameter type obi_req_t = obi_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter int unsigned NumSbrPorts = 2,
  parameter int unsigned MaxTrans = 4,
  localparam int unsigned IdxW =
    (NumSbrPorts > 1) ? $clog2(NumSbrPorts) : 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t sbr_ports_req_i [NumSbrPorts],
  output obi_rsp_t sbr_ports_rsp_o [NumSbrPorts],
  output obi_req_t mgr_port_req_o,
  input  obi_rsp_t mgr_port_rsp_i
);

  localparam int unsigned PtrW =
    (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic [IdxW-1:0] rr_ptr;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] head;
  logic            lock_q;

  logic [IdxW-1:0] mem [MaxTrans];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;

  logic any_req;
  logic can_issue;
  logic mgr_req;
  logic push;
  logic pop;
  logic head_rready;
  logic rsp_ok;

  function automatic logic [PtrW-1:0] ptr_inc(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scan downwards so the lowest offset from rr_ptr wins.
  always_comb begin
    int unsigned k;
    any_req = 1'b0;
    sel     = '0;
    for (int i = NumSbrPorts - 1; i >= 0; i--) begin
      k = (int'(rr_ptr) + i) % NumSbrPorts;
      if (sbr_ports_req_i[IdxW'(k)].req) begin
        any_req = 1'b1;
        sel     = IdxW'(k);
      end
    end
    if (lock_q) sel = lock_idx_q;
  end

  assign can_issue = (count < CntW'(MaxTrans));
  assign mgr_req   = !rst_i && can_issue
                   && (any_req || lock_q);
  assign push      = mgr_req && mgr_port_rsp_i.gnt;

  assign head        = mem[rd_ptr];
  assign head_rready = ObiCfg.UseRReady
                     ? sbr_ports_req_i[head].rready
                     : 1'b1;
  assign rsp_ok      = !rst_i && mgr_port_rsp_i.rvalid
                     && (count != '0);
  assign pop         = rsp_ok && head_rready;

  always_comb begin
    mgr_port_req_o        = sbr_ports_req_i[sel];
    mgr_port_req_o.req    = mgr_req;
    mgr_port_req_o.rready = ObiCfg.UseRReady
                          && !rst_i && head_rready;
    for (int i = 0; i < NumSbrPorts; i++) begin
      sbr_ports_rsp_o[i]        = mgr_port_rsp_i;
      sbr_ports_rsp_o[i].gnt    =
        push && (sel == IdxW'(i));
      sbr_ports_rsp_o[i].rvalid =
        rsp_ok && (head == IdxW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        lock_q <= 1'b0;
        rr_ptr <= (sel == IdxW'(NumSbrPorts - 1))
                ? '0 : sel + 1'b1;
      end else if (mgr_req) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= sel;
  end

  a_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (mgr_port_req_o.req && !mgr_port_rsp_i.gnt)
    |=> $stable(mgr_port_req_o.a));

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    push |-> (count != CntW'(MaxTrans)));

  a_no_underflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    mgr_port_rsp_i.rvalid |-> (count != '0));

endmodule
